// File: rtl/seg7_scan.sv
// Four-digit multiplexed seven-segment scanner. Digits are captured once per
// frame into shadow registers so a scan never mixes two different counts.
module seg7_scan #(
    parameter int SCAN_DIV   = 100000,
    parameter int BLANK_LEAD = 1
) (
    input  logic       C_CLK,
    input  logic       RST,
    input  logic       S_EN,
    input  logic [3:0] D_IN3,
    input  logic [3:0] D_IN2,
    input  logic [3:0] D_IN1,
    input  logic [3:0] D_IN0,
    input  logic [3:0] DP_IN,
    output logic [3:0] AN,
    output logic [6:0] SEG,
    output logic       DP,
    output logic       SCAN_TICK
);

    localparam logic [19:0] CNT_LAST = 20'(SCAN_DIV - 1);

    logic [19:0] cnt;
    logic [1:0]  idx;
    logic [3:0]  sh_dig [4];
    logic [3:0]  sh_dp;

    logic        slot_end;
    logic [3:0]  cur_dig;
    logic        blank;
    logic [6:0]  seg_next;
    logic [3:0]  an_next;

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    assign slot_end = (cnt == CNT_LAST);

    always_comb begin
        cur_dig  = sh_dig[idx];
        blank    = 1'b0;
        // A digit is a leading zero only if it and every digit above it are 0.
        case (idx)
            2'd3:    blank = (sh_dig[3] == 4'd0);
            2'd2:    blank = (sh_dig[3] == 4'd0) && (sh_dig[2] == 4'd0);
            2'd1:    blank = (sh_dig[3] == 4'd0) && (sh_dig[2] == 4'd0)
                             && (sh_dig[1] == 4'd0);
            default: blank = 1'b0;
        endcase
        if (BLANK_LEAD != 0 && blank)
            seg_next = 7'b1111111;
        else
            seg_next = decode(cur_dig);
        an_next      = 4'b1111;
        an_next[idx] = 1'b0;
    end

    always_ff @(posedge C_CLK) begin
        if (RST) begin
            cnt       <= '0;
            idx       <= '0;
            sh_dig[0] <= '0;
            sh_dig[1] <= '0;
            sh_dig[2] <= '0;
            sh_dig[3] <= '0;
            sh_dp     <= '0;
            AN        <= 4'b1111;
            SEG       <= 7'b1111111;
            DP        <= 1'b1;
            SCAN_TICK <= 1'b0;
        end else if (S_EN) begin
            SCAN_TICK <= 1'b0;
            if (slot_end) begin
                cnt       <= '0;
                idx       <= idx + 2'd1;
                SCAN_TICK <= 1'b1;
                if (idx == 2'd3) begin
                    sh_dig[3] <= D_IN3;
                    sh_dig[2] <= D_IN2;
                    sh_dig[1] <= D_IN1;
                    sh_dig[0] <= D_IN0;
                    sh_dp     <= DP_IN;
                end
            end else begin
                cnt <= cnt + 20'd1;
            end
            // Output stage samples pre-edge idx/shadow, so it trails idx by a cycle.
            AN  <= an_next;
            SEG <= seg_next;
            DP  <= ~sh_dp[idx];
        end else begin
            SCAN_TICK <= 1'b0;
            AN        <= 4'b1111;
            SEG       <= 7'b1111111;
            DP        <= 1'b1;
        end
    end

endmodule
